// File: rtl/pito_pkg.sv
// Shared types and status-word layout for the barrel-core MVU launcher.
package pito_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } mvu_launch_state_e;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_FULL_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_TMO_BIT   = 4;
  localparam int ST_LEVEL_LSB = 8;
  localparam int ST_LEVEL_W   = 8;
  localparam int ST_DONE_LSB  = 16;

  localparam int MVU_DONE_CNT_W = 16;

endpackage

// File: rtl/rv32_mvu_launch_lane.sv
// One hart's MVU launch lane: command FIFO, launch FSM, done counter and status word.
// Optional BUSY watchdog built only when MVU_LAUNCH_TIMEOUT_EN is defined.
//
//  state  | meaning
//  IDLE   | waiting for a queued command
//  LAUNCH | mvu_start high, popped head presented on mvu_command
//  BUSY   | MVU running, waiting for mvu_done (or watchdog)
module rv32_mvu_launch_lane
  import pito_pkg::*;
#(
  parameter int QDEPTH = 4
`ifdef MVU_LAUNCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65536
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_push,
  input  logic [31:0] cmd_data,
  input  logic        flush,
  input  logic        mvu_done,
  output logic        cmd_full,
  output logic        mvu_start,
  output logic [31:0] mvu_command,
  output logic        mvu_irq,
  output logic [31:0] status
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int LVL_W = $clog2(QDEPTH + 1);

  logic [31:0]               mem [QDEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [LVL_W-1:0]          level;
  logic                      ovf;
  logic [MVU_DONE_CNT_W-1:0] done_cnt;
  mvu_launch_state_e         state;

  logic empty;
  logic full;
  logic push_ok;
  logic launch;

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(QDEPTH));
  assign push_ok  = cmd_push & ~full & ~flush;
  // A flush in the same cycle empties the queue, so it also suppresses a launch.
  assign launch   = (state == IDLE) & ~empty & ~flush;
  assign cmd_full = full;

`ifdef MVU_LAUNCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  logic [TMR_W-1:0] tmr;
  logic             tmo;
  logic             timeout_hit;

  assign timeout_hit = (state == BUSY) & ~mvu_done & (tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
      tmo <= 1'b0;
    end else begin
      if (state == LAUNCH)
        tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
      else if (state == BUSY && tmr != '0)
        tmr <= tmr - TMR_W'(1);
      if (timeout_hit)
        tmo <= 1'b1;
      else if (flush)
        tmo <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      ovf         <= 1'b0;
      done_cnt    <= '0;
      state       <= IDLE;
      mvu_start   <= 1'b0;
      mvu_irq     <= 1'b0;
      mvu_command <= '0;
    end else begin
      mvu_start <= 1'b0;
      mvu_irq   <= 1'b0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (launch)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (cmd_push && full)
          ovf <= 1'b1;
        case ({push_ok, launch})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end

      case (state)
        IDLE: begin
          if (launch) begin
            state       <= LAUNCH;
            mvu_start   <= 1'b1;
            mvu_command <= mem[rd_ptr];
          end
        end
        LAUNCH: state <= BUSY;
        BUSY: begin
          if (mvu_done) begin
            state    <= IDLE;
            mvu_irq  <= 1'b1;
            done_cnt <= done_cnt + MVU_DONE_CNT_W'(1);
          end
`ifdef MVU_LAUNCH_TIMEOUT_EN
          else if (timeout_hit) begin
            state   <= IDLE;
            mvu_irq <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status                                       = '0;
    status[ST_BUSY_BIT]                          = (state != IDLE);
    status[ST_EMPTY_BIT]                         = empty;
    status[ST_FULL_BIT]                          = full;
    status[ST_OVF_BIT]                           = ovf;
    status[ST_LEVEL_LSB +: ST_LEVEL_W]           = ST_LEVEL_W'(level);
    status[ST_DONE_LSB +: MVU_DONE_CNT_W]        = done_cnt;
`ifdef MVU_LAUNCH_TIMEOUT_EN
    status[ST_TMO_BIT]                           = tmo;
`endif
  end

endmodule

// File: rtl/rv32_barrel_mvu_launcher.sv
// Per-hart queued MVU job launcher: NUM_HARTS independent lanes plus a hart_id-indexed status mux.
// MVU_LAUNCH_TIMEOUT_EN adds the per-lane BUSY watchdog and the TIMEOUT_CYCLES parameter.
module rv32_barrel_mvu_launcher
  import pito_pkg::*;
#(
  parameter int NUM_HARTS      = 8,
  parameter int QDEPTH         = 4,
`ifdef MVU_LAUNCH_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 65536,
`endif
  // One spare bit so out-of-range hart ids are representable and read as 0.
  parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_HARTS-1:0]      cmd_push,
  input  logic [32*NUM_HARTS-1:0]   cmd_data,
  output logic [NUM_HARTS-1:0]      cmd_full,
  input  logic [NUM_HARTS-1:0]      flush,
  output logic [NUM_HARTS-1:0]      mvu_start,
  output logic [32*NUM_HARTS-1:0]   mvu_command,
  input  logic [NUM_HARTS-1:0]      mvu_done,
  output logic [NUM_HARTS-1:0]      mvu_irq,
  input  logic [HART_CNT_WIDTH-1:0] hart_id_i,
  output logic [31:0]               status_rdata
);

  logic [31:0] lane_status [NUM_HARTS];

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_lane
    rv32_mvu_launch_lane #(
      .QDEPTH         (QDEPTH)
`ifdef MVU_LAUNCH_TIMEOUT_EN
      , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_push    (cmd_push[h]),
      .cmd_data    (cmd_data[h*32 +: 32]),
      .flush       (flush[h]),
      .mvu_done    (mvu_done[h]),
      .cmd_full    (cmd_full[h]),
      .mvu_start   (mvu_start[h]),
      .mvu_command (mvu_command[h*32 +: 32]),
      .mvu_irq     (mvu_irq[h]),
      .status      (lane_status[h])
    );
  end

  always_comb begin
    status_rdata = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hart_id_i == HART_CNT_WIDTH'(h))
        status_rdata = lane_status[h];
    end
  end

endmodule

// File: tb/tb_rv32_barrel_mvu_launcher.sv
// Self-checking bench for rv32_barrel_mvu_launcher: directed scenarios plus randomized traffic
// compared against a queue-based per-hart reference model.
module tb_rv32_barrel_mvu_launcher;

  localparam int NH = 8;
  localparam int QD = 4;
  localparam int TO = 16;
`ifdef MVU_LAUNCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NH-1:0]   push, flush, done;
  logic [32*NH-1:0] data;
  logic [3:0]      hid;
  logic [NH-1:0]   cmd_full, mvu_start, mvu_irq;
  logic [32*NH-1:0] mvu_command;
  logic [31:0]     status_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32_barrel_mvu_launcher #(
    .NUM_HARTS (NH),
    .QDEPTH    (QD)
`ifdef MVU_LAUNCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_push     (push),
    .cmd_data     (data),
    .cmd_full     (cmd_full),
    .flush        (flush),
    .mvu_start    (mvu_start),
    .mvu_command  (mvu_command),
    .mvu_done     (done),
    .mvu_irq      (mvu_irq),
    .hart_id_i    (hid),
    .status_rdata (status_rdata)
  );

  // Reference model: per-hart job queue, phase 0=idle 1=launching 2=running.
  logic [31:0] mq [NH][$];
  int          mph [NH];
  int          mbusy_cycles [NH];
  logic [NH-1:0] m_start, m_irq, m_ovf, m_tmo;
  logic [31:0] m_cmd [NH];
  logic [15:0] m_done [NH];

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      mq[h].delete();
      mph[h] = 0;
      mbusy_cycles[h] = 0;
      m_cmd[h] = '0;
      m_done[h] = '0;
    end
    m_start = '0; m_irq = '0; m_ovf = '0; m_tmo = '0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int h = 0; h < NH; h++) begin
      int sz;
      bit take;
      sz = mq[h].size();
      take = (mph[h] == 0) && (sz > 0) && !flush[h];
      m_start[h] = 1'b0;
      m_irq[h] = 1'b0;
      if (take) begin
        m_cmd[h] = mq[h].pop_front();
        m_start[h] = 1'b1;
      end
      if (flush[h]) begin
        mq[h].delete();
        m_ovf[h] = 1'b0;
        m_tmo[h] = 1'b0;
      end else if (push[h]) begin
        if (sz >= QD) m_ovf[h] = 1'b1;
        else mq[h].push_back(data[h*32 +: 32]);
      end
      if (mph[h] == 0) begin
        if (take) mph[h] = 1;
      end else if (mph[h] == 1) begin
        mph[h] = 2;
        mbusy_cycles[h] = 0;
      end else begin
        if (done[h]) begin
          mph[h] = 0;
          m_irq[h] = 1'b1;
          m_done[h] = m_done[h] + 16'd1;
        end else if (TO_EN) begin
          mbusy_cycles[h]++;
          if (mbusy_cycles[h] == TO) begin
            mph[h] = 0;
            m_irq[h] = 1'b1;
            m_tmo[h] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] model_status(int h);
    logic [31:0] s;
    if (h >= NH) return 32'h0;
    s = {m_done[h], 8'(mq[h].size()), 3'b000, m_tmo[h], m_ovf[h],
         (mq[h].size() == QD), (mq[h].size() == 0), (mph[h] != 0)};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    push = '0; flush = '0; done = '0; data = '0; hid = '0;
    #1 rst_n = 1'b0;
    tick();
    total++; if (mvu_start !== '0) begin bad++; $display("FAIL reset_start got=%0h want=0", mvu_start); end
    total++; if (mvu_irq !== '0) begin bad++; $display("FAIL reset_irq got=%0h want=0", mvu_irq); end
    total++; if (mvu_command !== '0) begin bad++; $display("FAIL reset_cmd got=%0h want=0", mvu_command); end
    total++; if (cmd_full !== '0) begin bad++; $display("FAIL reset_full got=%0h want=0", cmd_full); end
    #1;
    total++; if (status_rdata !== 32'h2) begin bad++; $display("FAIL reset_status got=%0h want=2", status_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_launch();
    hid = 4'd3;
    push[3] = 1'b1; data[3*32 +: 32] = 32'hA5;
    tick();
    push = '0;
    total++; if (mvu_start[3] !== 1'b0) begin bad++; $display("FAIL t1_start_early got=%0b want=0", mvu_start[3]); end
    tick();
    total++; if (mvu_start[3] !== 1'b1) begin bad++; $display("FAIL t1_start got=%0b want=1", mvu_start[3]); end
    total++; if (mvu_command[3*32 +: 32] !== 32'hA5) begin bad++; $display("FAIL t1_cmd got=%0h want=a5", mvu_command[3*32 +: 32]); end
    repeat (9) tick();
    done[3] = 1'b1;
    tick();
    done = '0;
    total++; if (mvu_irq[3] !== 1'b1) begin bad++; $display("FAIL t1_irq got=%0b want=1", mvu_irq[3]); end
    total++; if (status_rdata !== 32'h0001_0002) begin bad++; $display("FAIL t1_status got=%0h want=10002", status_rdata); end
    tick();
    total++; if (mvu_irq[3] !== 1'b0) begin bad++; $display("FAIL t1_irq_pulse got=%0b want=0", mvu_irq[3]); end
  endtask

  task automatic test_overflow();
    hid = 4'd0;
    push[0] = 1'b1; data[31:0] = 32'h100;
    tick(); push = '0;
    tick(); tick();
    for (int i = 0; i < QD + 1; i++) begin
      push[0] = 1'b1; data[31:0] = 32'h200 + i;
      tick();
    end
    push = '0;
    total++; if (cmd_full[0] !== 1'b1) begin bad++; $display("FAIL t2_full got=%0b want=1", cmd_full[0]); end
    total++; if (status_rdata !== 32'h0000_040D) begin bad++; $display("FAIL t2_status got=%0h want=40d", status_rdata); end
    done[0] = 1'b1; tick(); done = '0;
    for (int k = 0; k < QD; k++) begin
      int n = 0;
      while (mvu_start[0] !== 1'b1 && n < 6) begin tick(); n++; end
      total++; if (mvu_start[0] !== 1'b1) begin bad++; $display("FAIL t2_wait_start job=%0d got=0 want=1", k); end
      total++; if (mvu_command[31:0] !== 32'h200 + k) begin bad++; $display("FAIL t2_order got=%0h want=%0h", mvu_command[31:0], 32'h200 + k); end
      tick();
      done[0] = 1'b1; tick(); done = '0;
    end
    total++; if (status_rdata !== 32'h0005_000A) begin bad++; $display("FAIL t2_final got=%0h want=5000a", status_rdata); end
  endtask

  task automatic test_push_pop();
    hid = 4'd1;
    push[1] = 1'b1; data[32 +: 32] = 32'h300;
    tick(); push = '0;
    tick(); tick();
    push[1] = 1'b1; data[32 +: 32] = 32'h301; tick();
    data[32 +: 32] = 32'h302; tick();
    push = '0;
    done[1] = 1'b1; tick(); done = '0;
    push[1] = 1'b1; data[32 +: 32] = 32'h303;
    tick(); push = '0;
    total++; if (mvu_start[1] !== 1'b1) begin bad++; $display("FAIL t3_start got=%0b want=1", mvu_start[1]); end
    total++; if (mvu_command[32 +: 32] !== 32'h301) begin bad++; $display("FAIL t3_cmd got=%0h want=301", mvu_command[32 +: 32]); end
    total++; if (status_rdata !== 32'h0001_0201) begin bad++; $display("FAIL t3_level got=%0h want=10201", status_rdata); end
    for (int k = 2; k <= 3; k++) begin
      int n = 0;
      tick();
      done[1] = 1'b1; tick(); done = '0;
      while (mvu_start[1] !== 1'b1 && n < 6) begin tick(); n++; end
      total++; if (mvu_command[32 +: 32] !== 32'h300 + k) begin bad++; $display("FAIL t3_order got=%0h want=%0h", mvu_command[32 +: 32], 32'h300 + k); end
    end
    tick();
    done[1] = 1'b1; tick(); done = '0;
    total++; if (status_rdata !== 32'h0004_0002) begin bad++; $display("FAIL t3_final got=%0h want=40002", status_rdata); end
  endtask

  task automatic test_flush();
    hid = 4'd2;
    push[2] = 1'b1; data[64 +: 32] = 32'h400;
    tick(); push = '0;
    tick(); tick();
    for (int i = 1; i <= 3; i++) begin
      push[2] = 1'b1; data[64 +: 32] = 32'h400 + i; tick();
    end
    push = '0;
    flush[2] = 1'b1; tick(); flush = '0;
    total++; if (status_rdata !== 32'h0000_0003) begin bad++; $display("FAIL t4_flush got=%0h want=3", status_rdata); end
    repeat (3) tick();
    done[2] = 1'b1; tick(); done = '0;
    total++; if (mvu_irq[2] !== 1'b1) begin bad++; $display("FAIL t4_irq got=%0b want=1", mvu_irq[2]); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (mvu_start[2] !== 1'b0) begin bad++; $display("FAIL t4_no_start got=%0b want=0", mvu_start[2]); end
    end
    push[2] = 1'b1; flush[2] = 1'b1; data[64 +: 32] = 32'h4FF;
    tick(); push = '0; flush = '0;
    total++; if (status_rdata !== 32'h0001_0002) begin bad++; $display("FAIL t4_flush_wins got=%0h want=10002", status_rdata); end
    tick();
    total++; if (mvu_start[2] !== 1'b0) begin bad++; $display("FAIL t4_flush_push_start got=%0b want=0", mvu_start[2]); end
  endtask

  task automatic test_timeout();
    hid = 4'd5;
    push[5] = 1'b1; data[5*32 +: 32] = 32'h500;
    tick(); push = '0;
    repeat (17) tick();
    total++; if (mvu_irq[5] !== 1'b0) begin bad++; $display("FAIL t5_irq_early got=%0b want=0", mvu_irq[5]); end
    tick();
`ifdef MVU_LAUNCH_TIMEOUT_EN
    total++; if (mvu_irq[5] !== 1'b1) begin bad++; $display("FAIL t5_irq got=%0b want=1", mvu_irq[5]); end
    total++; if (status_rdata !== 32'h0000_0012) begin bad++; $display("FAIL t5_status got=%0h want=12", status_rdata); end
`else
    total++; if (mvu_irq[5] !== 1'b0) begin bad++; $display("FAIL t5_irq got=%0b want=0", mvu_irq[5]); end
    total++; if (status_rdata !== 32'h0000_0003) begin bad++; $display("FAIL t5_status got=%0h want=3", status_rdata); end
    done[5] = 1'b1; tick(); done = '0;
    total++; if (mvu_irq[5] !== 1'b1) begin bad++; $display("FAIL t5_irq_done got=%0b want=1", mvu_irq[5]); end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int h = 0; h < NH; h++) begin
        push[h] = ($urandom_range(0, 2) == 0);
        data[h*32 +: 32] = $urandom;
        flush[h] = ($urandom_range(0, 39) == 0);
        done[h] = ($urandom_range(0, 3) == 0);
      end
      hid = 4'($urandom_range(0, 15));
      tick();
      total++; if (mvu_start !== m_start) begin bad++; $display("FAIL rnd_start cyc=%0d got=%0h want=%0h", c, mvu_start, m_start); end
      total++; if (mvu_irq !== m_irq) begin bad++; $display("FAIL rnd_irq cyc=%0d got=%0h want=%0h", c, mvu_irq, m_irq); end
      for (int h = 0; h < NH; h++) begin
        total++; if (mvu_command[h*32 +: 32] !== m_cmd[h]) begin bad++; $display("FAIL rnd_cmd cyc=%0d hart=%0d got=%0h want=%0h", c, h, mvu_command[h*32 +: 32], m_cmd[h]); end
        total++; if (cmd_full[h] !== (mq[h].size() == QD)) begin bad++; $display("FAIL rnd_full cyc=%0d hart=%0d got=%0b want=%0b", c, h, cmd_full[h], mq[h].size() == QD); end
      end
      total++; if (status_rdata !== model_status(int'(hid))) begin bad++; $display("FAIL rnd_status cyc=%0d hid=%0d got=%0h want=%0h", c, hid, status_rdata, model_status(int'(hid))); end
    end
    push = '0; flush = '0; done = '0;
  endtask

  task automatic test_reset_mid_busy();
    for (int h = 0; h < NH; h++) begin
      push[h] = 1'b1; data[h*32 +: 32] = 32'h600 + h;
    end
    tick(); push = '0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (mvu_start !== '0) begin bad++; $display("FAIL t6_start got=%0h want=0", mvu_start); end
    total++; if (mvu_irq !== '0) begin bad++; $display("FAIL t6_irq got=%0h want=0", mvu_irq); end
    total++; if (mvu_command !== '0) begin bad++; $display("FAIL t6_cmd got=%0h want=0", mvu_command); end
    total++; if (cmd_full !== '0) begin bad++; $display("FAIL t6_full got=%0h want=0", cmd_full); end
    for (int h = 0; h < NH; h++) begin
      hid = 4'(h);
      #1;
      total++; if (status_rdata !== 32'h0000_0002) begin bad++; $display("FAIL t6_status hart=%0d got=%0h want=2", h, status_rdata); end
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    hid = 4'd9;
    tick();
    total++; if (status_rdata !== 32'h0) begin bad++; $display("FAIL t6_hid_range got=%0h want=0", status_rdata); end
    total++; if (mvu_start !== '0) begin bad++; $display("FAIL t6_post_start got=%0h want=0", mvu_start); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_launch();
    test_overflow();
    test_push_pop();
    test_flush();
    test_timeout();
    test_random();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
